hazard_interlock: RTL
=====================

# hazard_interlock

Pipeline interlock for the 5-stage RISC-V core; it is the stall side of the operand-bypass network. The forwarding control only selects bypass sources. This block tracks in-flight destination registers in EX/MEM/WB and freezes IF/ID when a bypass cannot cover a dependency: a load result consumed by the next instruction. It also inserts the EX bubble, freezes the whole pipe while data memory is not ready, and keeps saturating stall statistics.

## Interface
- CNT_W, 16, width of each stall statistics counter
- clk  input  1  core clock; all state updates on rising edge
- rst_n  input  1  synchronous reset, active-low
- id_inst  input  32  instruction currently in ID
- id_valid  input  1  ID holds a real instruction (0 = bubble)
- mem_ready  input  1  data memory ready; 0 freezes all stages
- stall_if  output  1  hold PC / IF register
- stall_id  output  1  hold IF/ID register
- stall_ex  output  1  hold ID/EX, EX/MEM and MEM/WB (memory wait)
- bubble_ex  output  1  load a NOP into ID/EX this edge
- state  output  2  0 RUN, 1 LSTALL, 2 MWAIT (registered)
- load_stall_cnt  output  CNT_W  count of load-use stall cycles, saturating
- mem_wait_cnt  output  CNT_W  count of memory-wait cycles, saturating

## Operation
- Decode of id_inst:
  - rs1 = [19:15], rs2 = [24:20], rd = [11:7], op = [6:0].
  - uses_rs1: op not in {0110111 LUI, 0010111 AUIPC, 1101111 JAL}.
  - uses_rs2: op in {0110011 R, 0100011 S, 1100011 B}.
  - writes_rd: op not in {S, B} and rd != 0.
  - is_load: op = 0000011.
- Shadow pipeline: three entries EX, MEM, WB, each {valid, wr, rd[4:0], load}.
- load_use (combinational) = id_valid & EX.valid & EX.wr & EX.load & ((uses_rs1 & rs1 == EX.rd) | (uses_rs2 & rs2 == EX.rd)).
  - x0 never hazards, because wr = 0 when rd = 0.
  - Exact 5-bit compare; X/Z on id_inst must not create a match when id_valid = 0.
- Outputs are combinational, priority order:
  - mem_ready = 0: stall_if = stall_id = stall_ex = 1; bubble_ex = 0.
  - else load_use: stall_if = stall_id = bubble_ex = 1; stall_ex = 0.
  - else all 0.
- Shadow update on each edge:
  - mem_ready = 0: all entries hold.
  - load_use: WB <= MEM, MEM <= EX, EX <= invalid.
  - else: WB <= MEM, MEM <= EX, EX <= {id_valid, writes_rd, rd, is_load}.
- State register, next state:
  - MWAIT if mem_ready = 0.
  - else LSTALL if load_use.
  - else RUN.
  - Any state can reach any state.
- Counters:
  - load_stall_cnt += 1 on each edge with mem_ready & load_use.
  - mem_wait_cnt += 1 on each edge with !mem_ready.
  - Both saturate at all-ones and never wrap.
- WB entry is kept for debug/visibility only; it never causes a stall, because the register file writes before it reads.

## Timing
- Reset (rst_n = 0 at an edge):
  - All shadow entries become invalid; state = RUN; both counters = 0.
  - Outputs derive from the reset state, so stall_* = bubble_ex = 0 unless mem_ready = 0.
- Reset mid-stall: the pending stall is discarded; the next cycle starts from RUN with an empty shadow.
- Load-use stall lasts exactly 1 cycle:
  - After the bubble edge, EX is invalid, so the same ID instruction proceeds the next cycle.
  - A dependency on MEM is covered by forwarding and never stalls.
- mem_ready low during a load-use cycle: only the freeze is asserted. The load-use stall reasserts in the first cycle mem_ready returns high, because shadow and ID were held.
- Back-to-back loads into dependent consumers: each consumer costs one stall cycle.
- Latency: stall outputs are same-cycle (zero latency); state and counters reflect the event one edge later.

## Test plan
- lw x5,0(x1)=0x0000A283 then add x6,x5,x7=0x00728333 -> stall_if = stall_id = bubble_ex = 1 for exactly one cycle; state = LSTALL next cycle; load_stall_cnt = 1; add enters EX on the following edge.
- lw x0,0(x1)=0x0000A003 then add x6,x0,x7=0x00700333 -> no stall. Also lw x5 then lui x6,0x2B=0x0002B337 (rs1 field = 5) -> no stall.
- lw x5 then nop, then add x6,x5,x7 -> no stall (MEM distance, forwarded).
- mem_ready low for 3 cycles during lw/add pair -> stall_ex = 1 and bubble_ex = 0 for 3 cycles; mem_wait_cnt = 3; then one load-use stall cycle; load_stall_cnt = 1.
- Preload counter to 0xFFFE via 2^16-2 stall cycles, then 3 more -> load_stall_cnt holds 0xFFFF.
- rst_n low during a load-use cycle -> next cycle state = RUN, counters 0, add proceeds with no stall.

Source files
------------

// File: rtl/hazard_interlock_if.sv
// Hazard interlock bus: ID-stage instruction and memory status in, pipeline stall
// controls and stall statistics out.
interface hazard_interlock_if #(
  parameter int unsigned CNT_W = 16
);
  logic [31:0]      id_inst;
  logic             id_valid;
  logic             mem_ready;
  logic             stall_if;
  logic             stall_id;
  logic             stall_ex;
  logic             bubble_ex;
  logic [1:0]       state;
  logic [CNT_W-1:0] load_stall_cnt;
  logic [CNT_W-1:0] mem_wait_cnt;

  modport master (
    output id_inst, id_valid, mem_ready,
    input  stall_if, stall_id, stall_ex, bubble_ex, state, load_stall_cnt, mem_wait_cnt
  );

  modport slave (
    input  id_inst, id_valid, mem_ready,
    output stall_if, stall_id, stall_ex, bubble_ex, state, load_stall_cnt, mem_wait_cnt
  );
endinterface

// File: rtl/hazard_interlock.sv
// Load-use / memory-wait interlock for the 5-stage core: tracks in-flight destinations
// in a shadow EX/MEM/WB pipe and stalls IF/ID when forwarding cannot cover a load result.
module hazard_interlock #(
  parameter int unsigned CNT_W = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  hazard_interlock_if.slave bus
);

  localparam int unsigned REG_W = 5;
  localparam int unsigned OP_W  = 7;

  localparam logic [OP_W-1:0] OP_LUI   = 7'b0110111;
  localparam logic [OP_W-1:0] OP_AUIPC = 7'b0010111;
  localparam logic [OP_W-1:0] OP_JAL   = 7'b1101111;
  localparam logic [OP_W-1:0] OP_R     = 7'b0110011;
  localparam logic [OP_W-1:0] OP_S     = 7'b0100011;
  localparam logic [OP_W-1:0] OP_B     = 7'b1100011;
  localparam logic [OP_W-1:0] OP_LOAD  = 7'b0000011;

  typedef struct packed {
    logic             valid;
    logic             wr;
    logic [REG_W-1:0] rd;
    logic             load;
  } shadow_t;

  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_LSTALL = 2'd1,
    ST_MWAIT  = 2'd2
  } state_t;

  logic [REG_W-1:0] w_rs1;
  logic [REG_W-1:0] w_rs2;
  logic [REG_W-1:0] w_rd;
  logic [OP_W-1:0]  w_op;
  logic             w_uses_rs1;
  logic             w_uses_rs2;
  logic             w_writes_rd;
  logic             w_is_load;
  logic             w_rs1_hit;
  logic             w_rs2_hit;
  logic             w_load_use;
  shadow_t          w_ex_fill;
  state_t           w_state_next;
  logic             w_unused;

  shadow_t          r_ex;
  shadow_t          r_mem;
  shadow_t          r_wb;
  state_t           r_state;
  logic [CNT_W-1:0] r_load_stall_cnt;
  logic [CNT_W-1:0] r_mem_wait_cnt;

  // ID-stage field decode
  assign w_rs1 = bus.id_inst[19:15];
  assign w_rs2 = bus.id_inst[24:20];
  assign w_rd  = bus.id_inst[11:7];
  assign w_op  = bus.id_inst[6:0];

  assign w_uses_rs1  = !((w_op == OP_LUI) || (w_op == OP_AUIPC) || (w_op == OP_JAL));
  assign w_uses_rs2  = (w_op == OP_R) || (w_op == OP_S) || (w_op == OP_B);
  assign w_writes_rd = !((w_op == OP_S) || (w_op == OP_B)) && (w_rd != '0);
  assign w_is_load   = (w_op == OP_LOAD);

  // Only an EX-stage load is too late for the bypass; MEM/WB are forwarded.
  assign w_rs1_hit  = w_uses_rs1 && (w_rs1 == r_ex.rd);
  assign w_rs2_hit  = w_uses_rs2 && (w_rs2 == r_ex.rd);
  assign w_load_use = bus.id_valid && r_ex.valid && r_ex.wr && r_ex.load &&
                      (w_rs1_hit || w_rs2_hit);

  // A bubble in ID must enter EX with clean fields even if id_inst is undriven.
  always_comb begin
    w_ex_fill       = '0;
    w_ex_fill.valid = bus.id_valid;
    w_ex_fill.wr    = bus.id_valid && w_writes_rd;
    w_ex_fill.rd    = bus.id_valid ? w_rd : '0;
    w_ex_fill.load  = bus.id_valid && w_is_load;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_ex  <= '0;
      r_mem <= '0;
      r_wb  <= '0;
    end else if (bus.mem_ready) begin
      r_wb  <= r_mem;
      r_mem <= r_ex;
      r_ex  <= w_load_use ? shadow_t'('0) : w_ex_fill;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= ST_RUN;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = ST_RUN;
    if (!bus.mem_ready) begin
      w_state_next = ST_MWAIT;
    end else if (w_load_use) begin
      w_state_next = ST_LSTALL;
    end
  end

  // Memory wait outranks the load-use bubble: the whole pipe freezes instead.
  always_comb begin
    bus.stall_if  = 1'b0;
    bus.stall_id  = 1'b0;
    bus.stall_ex  = 1'b0;
    bus.bubble_ex = 1'b0;
    if (!bus.mem_ready) begin
      bus.stall_if = 1'b1;
      bus.stall_id = 1'b1;
      bus.stall_ex = 1'b1;
    end else if (w_load_use) begin
      bus.stall_if  = 1'b1;
      bus.stall_id  = 1'b1;
      bus.bubble_ex = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_load_stall_cnt <= '0;
      r_mem_wait_cnt   <= '0;
    end else begin
      if (bus.mem_ready && w_load_use && (r_load_stall_cnt != '1)) begin
        r_load_stall_cnt <= r_load_stall_cnt + CNT_W'(1);
      end
      if (!bus.mem_ready && (r_mem_wait_cnt != '1)) begin
        r_mem_wait_cnt <= r_mem_wait_cnt + CNT_W'(1);
      end
    end
  end

  assign bus.state          = r_state;
  assign bus.load_stall_cnt = r_load_stall_cnt;
  assign bus.mem_wait_cnt   = r_mem_wait_cnt;

  // WB entry and non-register instruction bits are visibility-only.
  assign w_unused = ^{bus.id_inst[31:25], bus.id_inst[14:12], r_wb};

endmodule
